toggle_event_decoder: RTL and testbench
=======================================

# toggle_event_decoder

Receive-side decoder for toggle-encoded events: one event is signalled by one level change on a single line, as produced by a T flip-flop with t=1 on the sending side. The block synchronizes the asynchronous line, rejects glitches, emits a one-cycle `evt` pulse per accepted level change, and keeps a wrapping event counter with a sticky overflow flag. It sits between a board switch or a foreign-clock toggle source and LED/status logic in the lab top level.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flop count (≥2).
- `DEBOUNCE_CYCLES`, 16: consecutive cycles a new level must hold before it is accepted (≥1).
- `CNT_W`, 8: event counter width.

Ports:
- `clk` in 1: single clock; all state on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `tog_in` in 1: asynchronous toggle line.
- `clr` in 1: synchronous clear of `evt_count` and `ovf`.
- `evt` out 1: one-cycle pulse per accepted toggle.
- `level` out 1: current accepted (debounced) line level.
- `evt_count` out CNT_W: accepted-event count, wrapping.
- `ovf` out 1: sticky; set when `evt_count` wraps.

## Operation
- Reset (rst=1 at posedge): sync chain=0, `level`=0, FSM=STABLE, debounce counter=0, `evt`=0, `evt_count`=0, `ovf`=0. If `tog_in`=1 after reset, this is a level change and produces one event after the normal latency.
- Sync chain: `SYNC_STAGES` flops; `s` = last stage.
- Debounce FSM:
  - STABLE: if `s`≠`level`, go to PENDING with dcnt=1; otherwise stay.
  - PENDING: if `s`==`level`, go to STABLE, dcnt=0 (glitch rejected, no event). Else if dcnt==DEBOUNCE_CYCLES, flip `level`, pulse `evt`, go to STABLE. Else dcnt+1.
  - DEBOUNCE_CYCLES=1: the change is accepted on the first PENDING cycle.
  - dcnt width is $clog2(DEBOUNCE_CYCLES+1).
- Counter, in priority order:
  - `clr` → `evt_count`=0, `ovf`=0. A coincident event still pulses `evt` but is not counted.
  - Else on `evt`: `evt_count`+1 modulo 2^CNT_W. Wrap from all-ones to 0 sets `ovf`.
  - `ovf` clears only on `clr` or `rst`.
- `evt` is a registered output, never high two cycles in a row. Toggles spaced closer than the latency are merged or rejected. They are never queued.

## Timing
- `tog_in` change sampled at edge 0 → `s` changes after edge SYNC_STAGES-1 → `level` flips and `evt`=1 after edge SYNC_STAGES+DEBOUNCE_CYCLES. Debounced latency is SYNC_STAGES+DEBOUNCE_CYCLES+1 edges from the first sampling edge.
- `evt_count` updates one edge after `evt` is high.
- `rst` asserted mid-PENDING aborts the pending change. The output values after that edge are the reset values.

## Configuration
- `TOGGLE_DEC_DEBOUNCE_EN` defined: the debounce FSM is present as described.
- Undefined: FSM and dcnt are removed. `level` follows `s` with one register, and `evt` = (`s`≠`level`) registered. Latency is SYNC_STAGES+1 edges, and a glitch one cycle wide after sync produces an event. `DEBOUNCE_CYCLES` is ignored.

## Structure
- Package `toggle_dec_pkg`: FSM state encoding (STABLE=0, PENDING=1) and default parameter constants.
- Sub-module `sync_chain` (parameter STAGES, ports clk, rst, d, q; synchronous reset to 0). It is reused for other async board inputs.
- Remaining logic (FSM, counter) lives in `toggle_event_decoder`.

## Test plan
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=4 with the macro defined, unless noted.
- Single toggle: `tog_in` 0→1 held → `evt`=1 for exactly one cycle, 7 edges after the sampling edge. `level`=1, `evt_count`=1.
- Glitch: `tog_in` high for 3 cycles then low → no `evt`, `level`=0, `evt_count`=0.
- 17 accepted toggles → `evt_count` goes 15→0 on the 16th and `ovf`=1; after the 17th, `evt_count`=1 and `ovf` stays 1.
- `clr` on the same cycle as `evt` → `evt` pulses, then `evt_count`=0 and `ovf`=0.
- `rst` pulsed mid-PENDING with `tog_in`=1 held → all outputs 0. One event then fires 7 edges after `rst` deasserts.
- Macro undefined: a 1-cycle `tog_in` pulse → two `evt` pulses and `evt_count`=2.

Source files
------------

// File: rtl/toggle_dec_pkg.sv
// toggle_dec_pkg
// Shared definitions for the toggle event decoder: debounce FSM state
// encoding and the default parameter values used by toggle_event_decoder.
package toggle_dec_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } dec_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/sync_chain.sv
// sync_chain
// Multi-flop synchronizer for an asynchronous single-bit input. Generic so it
// can be reused for any async board input.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset, clears every stage to 0
//   d   - asynchronous input
//   q   - synchronized output (last stage)
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stg;

  // NOTE: sequential state is written with non-blocking assignments so every
  // stage samples the value its predecessor held before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg <= '0;
    end else begin
      stg <= {stg[STAGES-2:0], d};
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder
// Receive-side decoder for toggle-encoded events (one event = one level
// change on tog_in). Synchronizes the line, optionally debounces it, emits a
// one-cycle evt pulse per accepted change and counts events with a sticky
// wrap flag.
// Build option: define TOGGLE_DEC_DEBOUNCE_EN to include the debounce FSM.
// Without it, level follows the synchronized line through one register and
// every change (even a one-cycle glitch) produces an event.
// Ports:
//   clk       - clock, all state on posedge
//   rst       - synchronous active-high reset
//   tog_in    - asynchronous toggle line
//   clr       - synchronous clear of evt_count and ovf
//   evt       - one-cycle pulse per accepted level change
//   level     - current accepted line level
//   evt_count - wrapping accepted-event count
//   ovf       - sticky, set when evt_count wraps from all-ones to zero
module toggle_event_decoder
  import toggle_dec_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  input  logic             clr,
  output logic             evt,
  output logic             level,
  output logic [CNT_W-1:0] evt_count,
  output logic             ovf
);

  // Elaboration-time guard on the parameter ranges.
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
    $error("toggle_event_decoder: SYNC_STAGES>=2, DEBOUNCE_CYCLES>=1, CNT_W>=1 required");
  end

  logic s;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (tog_in),
    .q  (s)
  );

`ifdef TOGGLE_DEC_DEBOUNCE_EN
  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES);

  dec_state_e        state, state_nxt;
  logic [DCNT_W-1:0] dcnt, dcnt_nxt;
  logic              level_nxt, evt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE;
      dcnt  <= '0;
      level <= 1'b0;
      evt   <= 1'b0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
      level <= level_nxt;
      evt   <= evt_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt = state;
    dcnt_nxt  = dcnt;
    level_nxt = level;
    evt_nxt   = 1'b0;
    case (state)
      STABLE: begin
        if (s != level) begin
          state_nxt = PENDING;
          dcnt_nxt  = DCNT_W'(1);
        end
      end
      PENDING: begin
        if (s == level) begin
          // Line went back before the hold time elapsed: glitch, no event.
          state_nxt = STABLE;
          dcnt_nxt  = '0;
        end else if (dcnt == DCNT_MAX) begin
          state_nxt = STABLE;
          dcnt_nxt  = '0;
          level_nxt = ~level;
          evt_nxt   = 1'b1;
        end else begin
          dcnt_nxt = dcnt + DCNT_W'(1);
        end
      end
      default: begin
        state_nxt = STABLE;
        dcnt_nxt  = '0;
      end
    endcase
  end
`else
  // No debounce: any difference between the synchronized line and the
  // registered level is an event, one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      evt   <= 1'b0;
    end else begin
      level <= s;
      evt   <= s ^ level;
    end
  end
`endif

  // Event counter. clr wins over a coincident evt, which is then not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_count <= '0;
      ovf       <= 1'b0;
    end else if (clr) begin
      evt_count <= '0;
      ovf       <= 1'b0;
    end else if (evt) begin
      evt_count <= evt_count + CNT_W'(1);
      if (&evt_count) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// tb_toggle_event_decoder
// Directed bench for toggle_event_decoder (SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// CNT_W=4). Stimulus pushes the expected (cycle, level) of each event into a
// queue; a monitor on the falling edge pops and compares whenever evt is high.
// Counter/flag values are checked directly at quiet points. Expectations
// follow whichever build of TOGGLE_DEC_DEBOUNCE_EN is compiled.
module tb_toggle_event_decoder;

`ifdef TOGGLE_DEC_DEBOUNCE_EN
  localparam int LAT     = 7;  // sampling edge .. evt edge, inclusive
  localparam int PRE_RST = 4;  // cycles into PENDING before rst
  localparam bit DEB     = 1'b1;
`else
  localparam int LAT     = 3;
  localparam int PRE_RST = 1;  // reset while still in the sync chain
  localparam bit DEB     = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       tog_in;
  logic       clr;
  logic       evt;
  logic       level;
  logic [3:0] evt_count;
  logic       ovf;

  toggle_event_decoder #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tog_in   (tog_in),
    .clr      (clr),
    .evt      (evt),
    .level    (level),
    .evt_count(evt_count),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic lvl;
  } exp_evt_t;

  exp_evt_t exp_q[$];
  int total = 0;
  int bad   = 0;
  logic prev_evt = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int c, input logic l);
    exp_evt_t e;
    e.cyc = c;
    e.lvl = l;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (evt === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("evt_unexpected", evt, 0);
      end else begin
        exp_evt_t e;
        e = exp_q.pop_front();
        check("evt_cycle", cyc, e.cyc);
        check("evt_level", level, e.lvl);
      end
      if (DEB && prev_evt) check("evt_back_to_back", evt, 0);
    end
    prev_evt = evt;
  end

  task automatic do_reset();
    rst    = 1'b1;
    tog_in = 1'b0;
    clr    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_evt"}, evt, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_count"}, evt_count, 0);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    tog_in = 1'b0;
    clr    = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Single toggle 0->1 held.
    tog_in = 1'b1;
    push(cyc + LAT, 1'b1);
    repeat (LAT + 3) @(negedge clk);
    check("single_level", level, 1);
    check("single_count", evt_count, 1);

    // Three-cycle high glitch: rejected with debounce, two events without.
    do_reset();
    tog_in = 1'b1;
    if (!DEB) begin
      push(cyc + 3, 1'b1);
      push(cyc + 6, 1'b0);
    end
    repeat (3) @(negedge clk);
    tog_in = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_level", level, 0);
    check("glitch_count", evt_count, DEB ? 0 : 2);

    // 17 accepted toggles: wrap on the 16th sets ovf, which stays set.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      tog_in = ~tog_in;
      push(cyc + LAT, tog_in);
      repeat (LAT + 3) @(negedge clk);
      check($sformatf("wrap_count_%0d", i), evt_count, i % 16);
      check($sformatf("wrap_ovf_%0d", i), ovf, (i >= 16) ? 1 : 0);
    end

    // clr coincident with evt: event pulses but is not counted.
    tog_in = ~tog_in;
    push(cyc + LAT, tog_in);
    repeat (LAT) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    check("clr_count", evt_count, 0);
    check("clr_ovf", ovf, 0);

    // rst in the middle of a pending change aborts it.
    do_reset();
    tog_in = 1'b1;
    repeat (PRE_RST) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    push(cyc + LAT, 1'b1);
    repeat (LAT + 3) @(negedge clk);
    check("midrst_count", evt_count, 1);
    check("midrst_level", level, 1);

    // One-cycle pulse: two events without debounce, none with.
    do_reset();
    tog_in = 1'b1;
    if (!DEB) begin
      push(cyc + 3, 1'b1);
      push(cyc + 4, 1'b0);
    end
    @(negedge clk);
    tog_in = 1'b0;
    repeat (12) @(negedge clk);
    check("pulse_count", evt_count, DEB ? 0 : 2);
    check("pulse_level", level, 0);

    check("events_outstanding", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
